uart_tx: RTL

Serial 8N1 transmitter that sits directly upstream of the UART receiver in the link and drives the line the receiver samples. A byte is accepted over a valid/ready handshake and shifted out as one start bit (0), eight data bits LSB first, and one stop bit (1). Bit timing comes from an internal baud counter derived from the system clock, so no separate rate-generator instance is needed.

---
 rtl/uart_tx.sv | 79 +++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with valid/ready byte intake and internal baud timing
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Dout,
    output logic       busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shift, shift_n;
    logic            dout_n;
    logic            last;

    assign last     = cnt == CW'(CLKS_PER_BIT - 1);
    assign tx_ready = state == IDLE;
    assign busy     = !tx_ready;

    // State, timing and data registers; Dout is registered from the current state so it never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            Dout  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            Dout  <= dout_n;
        end
    end

    // Next-state decode: each bit lasts CLKS_PER_BIT cycles, advancing when the baud counter wraps
    always_comb begin
        state_n = state;
        cnt_n   = last ? '0 : cnt + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        dout_n  = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_valid) begin
                    state_n = START;
                    shift_n = tx_data;
                end
            end
            START: begin
                if (last) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (last) begin
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
